acc_dump_dec: RTL and testbench

//  Integrate-and-dump decimator. It sits directly upstream of the 1-to-2 demux in the digital chain.

---
 rtl/acc_dump_dec.sv | 98 +++++++++
 tb/tb_acc_dump_dec.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/acc_dump_dec.sv
// Integrate-and-dump decimator: sums 2**LOG2N signed samples and holds each frame sum on OUT.
// Optional input offset removal with output saturation is enabled by defining ACCDUMP_OFFSET_EN.
module acc_dump_dec #(
  parameter int BW    = 6,
  parameter int LOG2N = 4
) (
  input  logic                 CLK,
  input  logic                 RES,
  input  logic signed [BW-1:0] IN,
  input  logic                 IN_VLD,
  input  logic                 SYNC,
`ifdef ACCDUMP_OFFSET_EN
  input  logic signed [BW-1:0] OFFSET,
  output logic                 SAT,
`endif
  output logic signed [BW+3:0] OUT,
  output logic                 OUT_VLD
);

`ifdef ACCDUMP_OFFSET_EN
  localparam int AW = BW + 5;
`else
  localparam int AW = BW + 4;
`endif

  localparam logic [LOG2N-1:0] CNT_LAST = {LOG2N{1'b1}};
  localparam logic [LOG2N-1:0] CNT_ONE  = LOG2N'(1);

  logic [LOG2N-1:0]     r_cnt;
  logic signed [AW-1:0] r_acc;
  logic signed [AW-1:0] w_x;
  logic signed [AW-1:0] w_sum;
  logic                 w_last;

`ifdef ACCDUMP_OFFSET_EN
  localparam logic signed [AW-1:0] SMAX = AW'((1 <<< (BW + 3)) - 1);
  localparam logic signed [AW-1:0] SMIN = AW'(-(1 <<< (BW + 3)));

  logic signed [BW:0] w_diff;

  // Clamp the widened sum into the BW+4-bit output range.
  function automatic logic signed [BW+3:0] sat_out(input logic signed [AW-1:0] v);
    if (v > SMAX)      return SMAX[BW+3:0];
    else if (v < SMIN) return SMIN[BW+3:0];
    else               return v[BW+3:0];
  endfunction

  function automatic logic sat_hit(input logic signed [AW-1:0] v);
    return (v > SMAX) || (v < SMIN);
  endfunction

  assign w_diff = {IN[BW-1], IN} - {OFFSET[BW-1], OFFSET};
  assign w_x    = {{(AW-BW-1){w_diff[BW]}}, w_diff};
`else
  assign w_x    = {{(AW-BW){IN[BW-1]}}, IN};
`endif

  assign w_sum  = r_acc + w_x;
  assign w_last = (r_cnt == CNT_LAST);

  // Frame accumulation and dump; SYNC outranks a pending dump.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      OUT     <= '0;
      OUT_VLD <= 1'b0;
`ifdef ACCDUMP_OFFSET_EN
      SAT     <= 1'b0;
`endif
    end else begin
      OUT_VLD <= 1'b0;
`ifdef ACCDUMP_OFFSET_EN
      SAT     <= 1'b0;
`endif
      if (SYNC) begin
        r_acc <= IN_VLD ? w_x : '0;
        r_cnt <= IN_VLD ? CNT_ONE : '0;
      end else if (IN_VLD) begin
        if (w_last) begin
`ifdef ACCDUMP_OFFSET_EN
          OUT <= sat_out(w_sum);
          SAT <= sat_hit(w_sum);
`else
          OUT <= w_sum;
`endif
          OUT_VLD <= 1'b1;
          r_acc   <= '0;
          r_cnt   <= '0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_acc_dump_dec.sv
// Randomized and directed bench for acc_dump_dec against a frame-queue reference model.
// Define ACCDUMP_OFFSET_EN to exercise the offset/saturation build.
module tb_acc_dump_dec;
  localparam int BW    = 6;
  localparam int LOG2N = 4;
  localparam int N     = 1 << LOG2N;
  localparam int OMAX  = (1 << (BW + 3)) - 1;
  localparam int OMIN  = -(1 << (BW + 3));

  logic                 CLK = 1'b0;
  logic                 RES = 1'b0;
  logic signed [BW-1:0] IN = '0;
  logic                 IN_VLD = 1'b0;
  logic                 SYNC = 1'b0;
  logic signed [BW+3:0] OUT;
  logic                 OUT_VLD;
`ifdef ACCDUMP_OFFSET_EN
  logic signed [BW-1:0] OFFSET = '0;
  logic                 SAT;
  int                   exp_sat = 0;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  int frame[$];
  int exp_out = 0;
  int exp_vld = 0;
  int vld_cnt;
  int vld_at;

  always #5 CLK = ~CLK;

  acc_dump_dec #(.BW(BW), .LOG2N(LOG2N)) dut (
    .CLK    (CLK),
    .RES    (RES),
    .IN     (IN),
    .IN_VLD (IN_VLD),
    .SYNC   (SYNC),
`ifdef ACCDUMP_OFFSET_EN
    .OFFSET (OFFSET),
    .SAT    (SAT),
`endif
    .OUT    (OUT),
    .OUT_VLD(OUT_VLD)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Frame model: samples collect in a queue; the N-th one empties it into a dump.
  task automatic model_edge(input logic v, input int d, input logic s);
    int x;
    int sum;
    x = d;
`ifdef ACCDUMP_OFFSET_EN
    x = d - int'(OFFSET);
    exp_sat = 0;
`endif
    exp_vld = 0;
    if (s) begin
      frame.delete();
      if (v) frame.push_back(x);
    end else if (v) begin
      frame.push_back(x);
      if (frame.size() == N) begin
        sum = 0;
        foreach (frame[i]) sum += frame[i];
        frame.delete();
        exp_vld = 1;
        exp_out = sum;
`ifdef ACCDUMP_OFFSET_EN
        if (sum > OMAX) begin exp_out = OMAX; exp_sat = 1; end
        if (sum < OMIN) begin exp_out = OMIN; exp_sat = 1; end
`endif
      end
    end
  endtask

  task automatic model_reset();
    frame.delete();
    exp_out = 0;
    exp_vld = 0;
`ifdef ACCDUMP_OFFSET_EN
    exp_sat = 0;
`endif
  endtask

  task automatic compare(input string tag);
    chk({tag, "_out"}, int'(OUT), exp_out);
    chk({tag, "_vld"}, int'(OUT_VLD), exp_vld);
`ifdef ACCDUMP_OFFSET_EN
    chk({tag, "_sat"}, int'(SAT), exp_sat);
`endif
  endtask

  task automatic step(input string tag, input logic v, input int d, input logic s);
    IN_VLD = v;
    IN     = BW'(d);
    SYNC   = s;
    @(posedge CLK);
    model_edge(v, d, s);
    #1;
    compare(tag);
  endtask

  task automatic do_reset(input string tag);
    RES = 1'b1;
    IN_VLD = 1'b0;
    SYNC = 1'b0;
    #2;
    model_reset();
    compare({tag, "_in_rst"});
    @(posedge CLK);
    #1;
    compare({tag, "_rst_edge"});
    RES = 1'b0;
    step({tag, "_post_rst"}, 1'b0, 0, 1'b0);
  endtask

  initial begin
    do_reset("t0");

    // 1: full-scale positive frame
    for (int i = 0; i < N; i++) step("t1", 1'b1, 31, 1'b0);
    chk("t1_sum", int'(OUT), 496);
    chk("t1_strobe", int'(OUT_VLD), 1);
    step("t1_after", 1'b0, 0, 1'b0);
    chk("t1_hold", int'(OUT), 496);
    chk("t1_strobe_off", int'(OUT_VLD), 0);

    // 2: minimum code, then alternating samples
    for (int i = 0; i < N; i++) step("t2a", 1'b1, -32, 1'b0);
    chk("t2_min", int'(OUT), -512);
    for (int i = 0; i < N; i++) step("t2b", 1'b1, (i % 2 == 0) ? 5 : -3, 1'b0);
    chk("t2_alt", int'(OUT), 16);

    // 3: three idle cycles after every sample
    vld_cnt = 0;
    vld_at  = -1;
    for (int c = 0; c < 4 * N; c++) begin
      step("t3", (c % 4) == 0, 1, 1'b0);
      if (OUT_VLD) begin
        vld_cnt++;
        vld_at = c;
      end
    end
    chk("t3_sum", int'(OUT), 16);
    chk("t3_nstrobe", vld_cnt, 1);
    chk("t3_strobe_cycle", vld_at + 1, 61);

    // 4: SYNC with a sample restarts the frame
    for (int i = 0; i < 7; i++) step("t4a", 1'b1, 10, 1'b0);
    step("t4_sync", 1'b1, 2, 1'b1);
    for (int i = 0; i < N - 1; i++) step("t4b", 1'b1, 2, 1'b0);
    chk("t4_sum", int'(OUT), 32);
    chk("t4_strobe", int'(OUT_VLD), 1);

    // 5: reset mid-frame discards the partial sum
    for (int i = 0; i < 9; i++) step("t5a", 1'b1, 20, 1'b0);
    do_reset("t5");
    chk("t5_rst_out", int'(OUT), 0);
    for (int i = 0; i < N; i++) step("t5b", 1'b1, -1, 1'b0);
    chk("t5_sum", int'(OUT), -16);

`ifdef ACCDUMP_OFFSET_EN
    // 6: offset removal and clipping
    OFFSET = -32;
    for (int i = 0; i < N; i++) step("t6a", 1'b1, 31, 1'b0);
    chk("t6_clip", int'(OUT), 511);
    chk("t6_sat", int'(SAT), 1);
    OFFSET = 3;
    for (int i = 0; i < N; i++) step("t6b", 1'b1, 3, 1'b0);
    chk("t6_zero", int'(OUT), 0);
    chk("t6_nosat", int'(SAT), 0);
`endif

    // Random traffic with occasional SYNC and reset
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset("rnd");
      end else begin
`ifdef ACCDUMP_OFFSET_EN
        if ($urandom_range(0, 9) == 0) OFFSET = BW'($urandom_range(0, 63));
`endif
        step("rnd", $urandom_range(0, 9) < 7, int'($urandom_range(0, 63)) - 32,
             $urandom_range(0, 29) == 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
